// File: rtl/step_clock_ctrl.sv
// Run/step/breakpoint halt controller for the CPU clock domain.
// Optional cycle counter on o_runCycles: define STEP_CLOCK_CYCLE_COUNTER_EN.
module step_clock_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STEP_CNT_W      = 8,
  parameter int unsigned NUM_BP          = 4,
  localparam int unsigned BP_IDX_W       = $clog2(NUM_BP)
) (
  input  logic                  o_clk,
  input  logic                  o_resetn,
  input  logic                  i_btnStep,
  input  logic                  i_swStepNRun,
  input  logic                  i_swInstrNCycle,
  input  logic                  i_swEnableBreakpoint,
  input  logic [STEP_CNT_W-1:0] i_stepCount,
  input  logic [NUM_BP-1:0]     i_bpHitN,
  input  logic [NUM_BP-1:0]     i_bpMask,
  input  logic                  i_ctrlInstrFinishedN,
  output logic                  o_halt,
  output logic                  o_breakpointEnableN,
  output logic [1:0]            o_haltReason,
  output logic [BP_IDX_W-1:0]   o_bpIdx,
  output logic [31:0]           o_runCycles
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    RUN, HALTED, CYC_STEP, INSTR_STEP, BP_HALT
  } stateT;

  stateT state, stateNext;

  logic [3:0] syncA, syncB;
  logic btnSync, stepSync, instrSync, enSync;
  logic [DB_W-1:0] dbCnt;
  logic debounced, debouncedD, stepPulse;
  logic [STEP_CNT_W-1:0] cnt, cntNext;
  logic blank, blankNext;
  logic [BP_IDX_W-1:0] bpIdxNext, lowIdx;
  logic [NUM_BP-1:0] hitVec;
  logic bpHit, instrDone;

  assign {btnSync, stepSync, instrSync, enSync} = syncB;

  always_ff @(posedge o_clk or negedge o_resetn) begin
    if (!o_resetn) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= {i_btnStep, i_swStepNRun, i_swInstrNCycle, i_swEnableBreakpoint};
      syncB <= syncA;
    end
  end

  always_ff @(posedge o_clk or negedge o_resetn) begin
    if (!o_resetn) begin
      dbCnt      <= '0;
      debounced  <= 1'b0;
      debouncedD <= 1'b0;
      stepPulse  <= 1'b0;
    end else begin
      if (btnSync != debounced) begin
        if (dbCnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          debounced <= btnSync;
          dbCnt     <= '0;
        end else begin
          dbCnt <= dbCnt + 1'b1;
        end
      end else begin
        dbCnt <= '0;
      end
      debouncedD <= debounced;
      stepPulse  <= debounced & ~debouncedD;
    end
  end

  assign hitVec    = ~i_bpHitN & i_bpMask;
  assign bpHit     = (|hitVec) & enSync & ~blank;
  assign instrDone = ~i_ctrlInstrFinishedN;

  always_comb begin
    lowIdx = '0;
    for (int unsigned i = NUM_BP; i > 0; i--) begin
      if (hitVec[i-1]) lowIdx = BP_IDX_W'(i - 1);
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    bpIdxNext = o_bpIdx;
    blankNext = (blank && instrDone) ? 1'b0 : blank;
    case (state)
      RUN: begin
        if (bpHit) begin
          stateNext = BP_HALT;
          bpIdxNext = lowIdx;
        end else if (stepSync) begin
          stateNext = HALTED;
        end
      end
      HALTED: begin
        if (!stepSync) begin
          stateNext = RUN;
        end else if (stepPulse) begin
          cntNext   = (i_stepCount == '0) ? STEP_CNT_W'(1) : i_stepCount;
          stateNext = instrSync ? INSTR_STEP : CYC_STEP;
        end
      end
      CYC_STEP: begin
        cntNext = cnt - 1'b1;
        if (!stepSync) stateNext = RUN;
        else if (cnt == STEP_CNT_W'(1)) stateNext = HALTED;
      end
      INSTR_STEP: begin
        if (instrDone) cntNext = cnt - 1'b1;
        if (!stepSync) stateNext = RUN;
        else if (instrDone && cnt == STEP_CNT_W'(1)) stateNext = HALTED;
      end
      BP_HALT: begin
        // blank keeps the breakpoint that is still asserted from re-halting before the core retires one instruction
        if (stepPulse) begin
          stateNext = RUN;
          blankNext = 1'b1;
        end else if (stepSync) begin
          stateNext = HALTED;
        end
      end
      default: stateNext = RUN;
    endcase
    if (stateNext == RUN || stateNext == HALTED) cntNext = '0;
  end

  always_ff @(posedge o_clk or negedge o_resetn) begin
    if (!o_resetn) begin
      state        <= RUN;
      cnt          <= '0;
      blank        <= 1'b0;
      o_bpIdx      <= '0;
      o_halt       <= 1'b0;
      o_haltReason <= 2'b00;
    end else begin
      state        <= stateNext;
      cnt          <= cntNext;
      blank        <= blankNext;
      o_bpIdx      <= bpIdxNext;
      o_halt       <= (stateNext == HALTED) || (stateNext == BP_HALT);
      o_haltReason <= (stateNext == BP_HALT) ? 2'b10 :
                      (stateNext == HALTED)  ? 2'b01 : 2'b00;
    end
  end

  assign o_breakpointEnableN = ~enSync;

`ifdef STEP_CLOCK_CYCLE_COUNTER_EN
  always_ff @(posedge o_clk or negedge o_resetn) begin
    if (!o_resetn) o_runCycles <= '0;
    else if (!o_halt) o_runCycles <= o_runCycles + 32'd1;
  end
`else
  assign o_runCycles = '0;
`endif

endmodule
